// File: rtl/stopwatch_bcd.sv
// mm:ss stopwatch on four BCD digits, advanced by rising edges of the slow clk_div
// square wave, which is sampled as asynchronous data in the mclk domain.
module stopwatch_bcd #(
    parameter int         SYNC_STAGES  = 2,
    parameter logic [3:0] MIN_TENS_MAX = 4'd5
) (
    input  logic       mclk,
    input  logic       rst,
    input  logic       clk_div,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t                 state_r, state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   t_s;
    logic                   adv_s;
    logic                   zero_s;
    logic [4:0]             inc0_s, inc1_s, inc2_s, inc3_s;
    logic                   c0_s, c1_s, c2_s, c3_s;
    logic [3:0]             so_next_s, st_next_s, mo_next_s, mt_next_s;
    logic                   wrap_next_s;

    // Saturating-safe BCD step: {carry, next digit}; any value at or above max rolls to 0.
    function automatic logic [4:0] bcd_inc(input logic [3:0] d, input logic [3:0] max);
        if (d >= max) begin
            bcd_inc = {1'b1, 4'd0};
        end else begin
            bcd_inc = {1'b0, d + 4'd1};
        end
    endfunction

    assign t_s   = sync_r[SYNC_STAGES-1] & ~prev_r;
    assign adv_s = t_s & (state_r == RUN);

    // Synchroniser chain, rising-edge detector and registered tick
    always_ff @(posedge mclk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
            tick   <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], clk_div};
            prev_r <= sync_r[SYNC_STAGES-1];
            tick   <= t_s;
        end
    end

    // Next-state logic; clear only zeroes the count outside RUN
    always_comb begin
        state_next_s = state_r;
        zero_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (clear) begin
                    state_next_s = IDLE;
                    zero_s       = 1'b1;
                end else if (start_stop) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (start_stop) begin
                    state_next_s = PAUSE;
                end else begin
                    state_next_s = RUN;
                end
            end
            PAUSE: begin
                if (clear) begin
                    state_next_s = IDLE;
                    zero_s       = 1'b1;
                end else if (start_stop) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = PAUSE;
                end
            end
            default: begin
                state_next_s = IDLE;
                zero_s       = 1'b1;
            end
        endcase
    end

    // Digit carry chain: each digit steps only when every lower digit rolls over
    always_comb begin
        inc0_s      = bcd_inc(sec_ones, 4'd9);
        inc1_s      = bcd_inc(sec_tens, 4'd5);
        inc2_s      = bcd_inc(min_ones, 4'd9);
        inc3_s      = bcd_inc(min_tens, MIN_TENS_MAX);
        c0_s        = inc0_s[4];
        c1_s        = c0_s & inc1_s[4];
        c2_s        = c1_s & inc2_s[4];
        c3_s        = c2_s & inc3_s[4];
        so_next_s   = sec_ones;
        st_next_s   = sec_tens;
        mo_next_s   = min_ones;
        mt_next_s   = min_tens;
        wrap_next_s = 1'b0;
        if (zero_s) begin
            so_next_s = 4'd0;
            st_next_s = 4'd0;
            mo_next_s = 4'd0;
            mt_next_s = 4'd0;
        end else if (adv_s) begin
            so_next_s   = inc0_s[3:0];
            st_next_s   = c0_s ? inc1_s[3:0] : sec_tens;
            mo_next_s   = c1_s ? inc2_s[3:0] : min_ones;
            mt_next_s   = c2_s ? inc3_s[3:0] : min_tens;
            wrap_next_s = c3_s;
        end else begin
            wrap_next_s = 1'b0;
        end
    end

    // State, running flag, digits and wrap pulse
    always_ff @(posedge mclk) begin
        if (rst) begin
            state_r  <= IDLE;
            running  <= 1'b0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            wrap     <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            running  <= (state_next_s == RUN);
            sec_ones <= so_next_s;
            sec_tens <= st_next_s;
            min_ones <= mo_next_s;
            min_tens <= mt_next_s;
            wrap     <= wrap_next_s;
        end
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: stimulus queues expected digits per clk_div edge
// and per state probe; a negedge monitor pops and compares.
module tb_stopwatch_bcd;

    logic       mclk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_div = 1'b0;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic [3:0] sec_ones, sec_tens, min_ones, min_tens;
    logic       running, tick, wrap;

    stopwatch_bcd #(.SYNC_STAGES(2), .MIN_TENS_MAX(4'd5)) dut (
        .mclk(mclk), .rst(rst), .clk_div(clk_div),
        .start_stop(start_stop), .clear(clear),
        .sec_ones(sec_ones), .sec_tens(sec_tens),
        .min_ones(min_ones), .min_tens(min_tens),
        .running(running), .tick(tick), .wrap(wrap)
    );

    always #5 mclk = ~mclk;

    typedef struct {
        int          tst;
        logic [15:0] dig;
        logic        run;
        logic        wr;
        logic        tk;
    } exp_t;

    exp_t tick_q[$];
    exp_t probe_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_wrap = 0;
    int   m_sec = 0;
    logic m_run = 1'b0;
    logic done_req = 1'b0;
    logic done_ack = 1'b0;

    exp_t        mon_e;
    logic [15:0] mon_act;
    logic        mon_tick_prev = 1'b0;

    function automatic logic [15:0] to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    // Monitor: compare every tick against the tick queue and every pending probe
    always @(negedge mclk) begin
        mon_act = {min_tens, min_ones, sec_tens, sec_ones};
        if (tick === 1'b1) begin
            n_vec++;
            if (tick_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_tick: got tick with digits %h, required no tick", mon_act);
            end else begin
                mon_e = tick_q.pop_front();
                if (mon_act !== mon_e.dig || running !== mon_e.run || wrap !== mon_e.wr || mon_tick_prev) begin
                    n_err++;
                    $display("FAIL tick_t%0d: got digits=%h running=%b wrap=%b prev_tick=%b, required digits=%h running=%b wrap=%b prev_tick=0",
                             mon_e.tst, mon_act, running, wrap, mon_tick_prev, mon_e.dig, mon_e.run, mon_e.wr);
                end
            end
        end
        if (probe_q.size() > 0) begin
            mon_e = probe_q.pop_front();
            n_vec++;
            if (mon_act !== mon_e.dig || running !== mon_e.run || wrap !== mon_e.wr || tick !== mon_e.tk) begin
                n_err++;
                $display("FAIL probe_t%0d: got digits=%h running=%b wrap=%b tick=%b, required digits=%h running=%b wrap=%b tick=%b",
                         mon_e.tst, mon_act, running, wrap, tick, mon_e.dig, mon_e.run, mon_e.wr, mon_e.tk);
            end
        end
        if (wrap === 1'b1) n_wrap++;
        mon_tick_prev = (tick === 1'b1);
        if (done_req && !done_ack) begin
            n_vec++;
            if (tick_q.size() != 0) begin
                n_err++;
                $display("FAIL tick_count: got %0d expected ticks still pending, required 0", tick_q.size());
            end
            n_vec++;
            if (n_wrap != 1) begin
                n_err++;
                $display("FAIL wrap_count: got %0d wrap pulses, required 1", n_wrap);
            end
            done_ack = 1'b1;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic pulse(input logic ss, input logic cl);
        start_stop = ss;
        clear      = cl;
        cyc(1);
        start_stop = 1'b0;
        clear      = 1'b0;
        cyc(1);
    endtask

    task automatic probe(input int tst, input logic [15:0] d, input logic r);
        probe_q.push_back('{tst, d, r, 1'b0, 1'b0});
        cyc(2);
    endtask

    task automatic div_edge(input int tst);
        logic w;
        w = m_run && (m_sec == 3599);
        if (m_run) m_sec = (m_sec + 1) % 3600;
        tick_q.push_back('{tst, to_bcd(m_sec), m_run, w, 1'b1});
        clk_div = 1'b1;
        cyc(4);
        clk_div = 1'b0;
        cyc(4);
    endtask

    initial begin
        // 1: reset with clk_div toggling
        rst = 1'b1;
        clk_div = 1'b1; cyc(1);
        clk_div = 1'b0; cyc(1);
        clk_div = 1'b1; cyc(1);
        clk_div = 1'b0; cyc(1);
        rst = 1'b0;
        cyc(3);
        probe(1, 16'h0000, 1'b0);
        div_edge(1);
        probe(1, 16'h0000, 1'b0);

        // 2: start, ten edges
        pulse(1'b1, 1'b0); m_run = 1'b1;
        probe(2, 16'h0000, 1'b1);
        repeat (10) div_edge(2);
        probe(2, 16'h0010, 1'b1);

        // 3: run to 59:59, then wrap
        repeat (3589) div_edge(3);
        probe(3, 16'h5959, 1'b1);
        div_edge(3);
        probe(3, 16'h0000, 1'b1);

        // 4: clear ignored in RUN, pause holds, resume
        repeat (7) div_edge(4);
        probe(4, 16'h0007, 1'b1);
        pulse(1'b0, 1'b1);
        probe(4, 16'h0007, 1'b1);
        pulse(1'b1, 1'b0); m_run = 1'b0;
        probe(4, 16'h0007, 1'b0);
        repeat (5) div_edge(4);
        probe(4, 16'h0007, 1'b0);
        pulse(1'b1, 1'b0); m_run = 1'b1;
        repeat (3) div_edge(4);
        probe(4, 16'h0010, 1'b1);

        // 5: simultaneous start_stop and clear
        pulse(1'b1, 1'b0); m_run = 1'b0;
        pulse(1'b1, 1'b1); m_sec = 0;
        probe(5, 16'h0000, 1'b0);
        pulse(1'b1, 1'b0); m_run = 1'b1;
        repeat (4) div_edge(5);
        pulse(1'b1, 1'b1); m_run = 1'b0;
        probe(5, 16'h0004, 1'b0);
        div_edge(5);
        pulse(1'b1, 1'b0); m_run = 1'b1;
        div_edge(5);
        probe(5, 16'h0005, 1'b1);

        // 6: reset mid-count at 12:34
        repeat (749) div_edge(6);
        probe(6, 16'h1234, 1'b1);
        rst = 1'b1;
        cyc(1);
        probe_q.push_back('{6, 16'h0000, 1'b0, 1'b0, 1'b0});
        cyc(1);
        rst = 1'b0;
        m_sec = 0;
        m_run = 1'b0;
        cyc(2);
        repeat (3) div_edge(6);
        probe(6, 16'h0000, 1'b0);
        pulse(1'b1, 1'b0); m_run = 1'b1;
        div_edge(6);
        probe(6, 16'h0001, 1'b1);

        done_req = 1'b1;
        for (int i = 0; i < 20 && !done_ack; i++) cyc(1);
        if (!done_ack) begin
            n_vec++;
            n_err++;
            $display("FAIL final_check: monitor did not finish, required completion within 20 cycles");
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
